// File: rtl/nbit_acc_pkg.sv
// Shared definitions for the N-bit accumulator: FSM state encoding and job
// mode constants. Optional build macro used by this block: ACC_SATURATE_EN.
package nbit_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : nbit_acc_pkg

// File: rtl/nbit_accumulator_add_path.sv
// Combinational add/subtract step for the accumulator. Subtraction is done
// as acc + ~in_data + 1 through the ripple adder; a missing carry-out means
// a borrow. Under ACC_SATURATE_EN an overflowing step clamps instead of
// wrapping.
module acc_add_path
  import nbit_acc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] in_data,
  input  logic         sub_q,
  output logic [N-1:0] acc_next,
  output logic         ovf_bit
);

  logic [N-1:0] b_s;
  logic         c_in_s;
  logic [N-1:0] sum_s;
  logic         c_out_s;

  // Select adder operand b and carry-in from the job mode.
  always_comb begin
    b_s    = in_data;
    c_in_s = 1'b0;
    if (sub_q == MODE_SUB) begin
      b_s    = ~in_data;
      c_in_s = 1'b1;
    end else begin
      b_s    = in_data;
      c_in_s = 1'b0;
    end
  end

  ripple_adder #(.N(N)) u_adder (
    .a     (acc),
    .b     (b_s),
    .c_in  (c_in_s),
    .sum   (sum_s),
    .c_out (c_out_s)
  );

  // Interpret carry-out as overflow (add) or borrow (subtract) and form next acc.
  always_comb begin
    ovf_bit  = 1'b0;
    acc_next = sum_s;
    if (sub_q == MODE_SUB) begin
      ovf_bit = ~c_out_s;
    end else begin
      ovf_bit = c_out_s;
    end
`ifdef ACC_SATURATE_EN
    if (ovf_bit) begin
      if (sub_q == MODE_SUB) begin
        acc_next = {N{1'b0}};
      end else begin
        acc_next = {N{1'b1}};
      end
    end else begin
      acc_next = sum_s;
    end
`else
    acc_next = sum_s;
`endif
  end

endmodule : acc_add_path

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder datapath: sum = a + b + c_in, with carry-out.
module ripple_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] carry_s;

  assign carry_s[0] = c_in;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry_s[N];

endmodule : ripple_adder

// File: rtl/nbit_accumulator.sv
// N-bit accumulator stage: accumulates a programmed number of unsigned
// operands (add or subtract mode) and presents one result on a valid/ready
// output, with a sticky overflow/borrow flag.
// Optional build macro: ACC_SATURATE_EN (clamp instead of wrap).
module nbit_accumulator
  import nbit_acc_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sub,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          ovf,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r, state_next_s;
  logic [N-1:0]  acc_r, acc_next_s;
  logic [CW-1:0] remaining_r, remaining_next_s;
  logic          ovf_r, ovf_next_s;
  logic          sub_r, sub_next_s;
  logic          in_ready_r, out_valid_r, busy_r;

  logic [N-1:0]  step_acc_s;
  logic          step_ovf_s;

  acc_add_path #(.N(N)) u_add_path (
    .acc      (acc_r),
    .in_data  (in_data),
    .sub_q    (sub_r),
    .acc_next (step_acc_s),
    .ovf_bit  (step_ovf_s)
  );

  // Next-state and datapath-update decisions for the job FSM.
  always_comb begin
    state_next_s     = state_r;
    acc_next_s       = acc_r;
    remaining_next_s = remaining_r;
    ovf_next_s       = ovf_r;
    sub_next_s       = sub_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_next_s       = {N{1'b0}};
          ovf_next_s       = 1'b0;
          sub_next_s       = sub;
          remaining_next_s = len;
          if (len != {CW{1'b0}}) begin
            state_next_s = ACCUM;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_r) begin
          acc_next_s       = step_acc_s;
          ovf_next_s       = ovf_r | step_ovf_s;
          remaining_next_s = remaining_r - CNT_ONE;
          if (remaining_r == CNT_ONE) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ACCUM;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {N{1'b0}};
      remaining_r <= {CW{1'b0}};
      ovf_r       <= 1'b0;
      sub_r       <= MODE_ADD;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      acc_r       <= acc_next_s;
      remaining_r <= remaining_next_s;
      ovf_r       <= ovf_next_s;
      sub_r       <= sub_next_s;
      in_ready_r  <= (state_next_s == ACCUM);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = acc_r;
  assign ovf       = ovf_r;

endmodule : nbit_accumulator

// File: tb/tb_nbit_accumulator.sv
// Self-checking bench for nbit_accumulator (N=8, CW=4): directed vector
// table, hand-written reset/back-pressure sequences and randomized jobs
// against an arithmetic reference model.
module tb_nbit_accumulator;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sub;
  logic [CW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic          ovf;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  job_data [0:14];
  logic [14:0] job_stall;

  nbit_accumulator #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            s;
    int              n;
    logic [3:0][7:0] d;
    logic [3:0]      stall;
    logic [7:0]      exp_res;
    logic            exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic over the whole job.
  function automatic void model(input logic s, input int n,
                                output logic [7:0] r, output logic o);
    int total;
    int a;
    total = 0;
    a     = 0;
    o     = 1'b0;
    for (int i = 0; i < n; i++) total += int'(job_data[i]);
`ifdef ACC_SATURATE_EN
    for (int i = 0; i < n; i++) begin
      if (!s) begin
        a += int'(job_data[i]);
        if (a > 255) begin a = 255; o = 1'b1; end
      end else begin
        if (int'(job_data[i]) > a) begin a = 0; o = 1'b1; end
        else a -= int'(job_data[i]);
      end
    end
    r = 8'(a);
`else
    if (!s) begin
      r = 8'(total % 256);
      o = (total > 255);
    end else begin
      r = 8'((256 - (total % 256)) % 256);
      o = (total != 0);
    end
    a = total;
`endif
  endfunction

  // Run one complete job from IDLE, checking handshakes and the result.
  task automatic run_job(input string nm, input logic s, input int n,
                         input logic [7:0] er, input logic eo, input int hold);
    start = 1'b1; sub = s; len = 4'(n);
    tick();
    start = 1'b0;
    chk({nm, ".busy_after_start"}, int'(busy), 1);
    chk({nm, ".in_ready_after_start"}, int'(in_ready), (n != 0) ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      if (job_stall[i]) begin
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
        tick();
        chk({nm, ".stall_in_ready"}, int'(in_ready), 1);
        chk({nm, ".stall_no_valid"}, int'(out_valid), 0);
      end
      in_valid = 1'b1;
      in_data  = job_data[i];
      tick();
    end
    in_valid = 1'b0;
    chk({nm, ".out_valid"}, int'(out_valid), 1);
    chk({nm, ".in_ready_done"}, int'(in_ready), 0);
    chk({nm, ".result"}, int'(result), int'(er));
    chk({nm, ".ovf"}, int'(ovf), int'(eo));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      len       = 4'(3);
      tick();
      chk({nm, ".hold_valid"}, int'(out_valid), 1);
      chk({nm, ".hold_result"}, int'(result), int'(er));
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk({nm, ".released_valid"}, int'(out_valid), 0);
    tick();
    chk({nm, ".idle_busy"}, int'(busy), 0);
  endtask

  vec_t vecs [8];

  initial begin
    logic [7:0] er;
    logic       eo;
    int         nr;

    vecs[0] = '{"add3",   1'b0, 3, {8'd0, 8'd30, 8'd20, 8'd10}, 4'b0000, 8'd60, 1'b0};
`ifdef ACC_SATURATE_EN
    vecs[1] = '{"addovf", 1'b0, 2, {8'd0, 8'd0, 8'd100, 8'd200}, 4'b0000, 8'd255, 1'b1};
    vecs[2] = '{"sub1",   1'b1, 1, {8'd0, 8'd0, 8'd0, 8'd5},     4'b0000, 8'd0,   1'b1};
    vecs[7] = '{"addwrap",1'b0, 2, {8'd0, 8'd0, 8'd1, 8'd255},   4'b0000, 8'd255, 1'b1};
`else
    vecs[1] = '{"addovf", 1'b0, 2, {8'd0, 8'd0, 8'd100, 8'd200}, 4'b0000, 8'd44,  1'b1};
    vecs[2] = '{"sub1",   1'b1, 1, {8'd0, 8'd0, 8'd0, 8'd5},     4'b0000, 8'd251, 1'b1};
    vecs[7] = '{"addwrap",1'b0, 2, {8'd0, 8'd0, 8'd1, 8'd255},   4'b0000, 8'd0,   1'b1};
`endif
    vecs[3] = '{"len0",   1'b0, 0, {8'd0, 8'd0, 8'd0, 8'd0},     4'b0000, 8'd0,   1'b0};
    vecs[4] = '{"stall",  1'b0, 2, {8'd0, 8'd0, 8'd8, 8'd7},     4'b0010, 8'd15,  1'b0};
    vecs[5] = '{"subzero",1'b1, 2, {8'd0, 8'd0, 8'd0, 8'd0},     4'b0000, 8'd0,   1'b0};
    vecs[6] = '{"add255", 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'd255},   4'b0000, 8'd255, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; len = 4'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    job_stall = 15'd0;
    for (int i = 0; i < 15; i++) job_data[i] = 8'd0;
    tick();
    tick();
    chk("reset.in_ready", int'(in_ready), 0);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.result", int'(result), 0);
    chk("reset.ovf", int'(ovf), 0);
    rst = 1'b0;
    tick();

    // Reset mid-job after two operands, then a fresh single-operand job.
    start = 1'b1; sub = 1'b0; len = 4'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd200; tick();
    in_data = 8'd100; tick();
    in_valid = 1'b0;
    chk("midrst.partial_ovf", int'(ovf), 1);
    rst = 1'b1;
    #2;
    chk("midrst.async_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    chk("midrst.in_ready", int'(in_ready), 0);
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.result", int'(result), 0);
    chk("midrst.ovf", int'(ovf), 0);
    tick();
    chk("midrst.idle_busy", int'(busy), 0);
    job_data[0] = 8'd9;
    run_job("after_rst", 1'b0, 1, 8'd9, 1'b0, 0);

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) job_data[i] = vecs[v].d[i];
      job_stall = {11'd0, vecs[v].stall};
      run_job(vecs[v].name, vecs[v].s, vecs[v].n, vecs[v].exp_res,
              vecs[v].exp_ovf, (v == 4) ? 5 : 1);
    end

    // Randomized jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      nr = $urandom_range(0, 15);
      for (int i = 0; i < 15; i++) begin
        job_data[i]  = 8'($urandom_range(0, (j % 2 == 0) ? 255 : 20));
        job_stall[i] = ($urandom_range(0, 3) == 0);
      end
      sub = 1'($urandom_range(0, 1));
      model(sub, nr, er, eo);
      run_job("random", sub, nr, er, eo, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_nbit_accumulator

// File: doc/nbit_accumulator.md
Name: nbit_accumulator

Overview:
- Sequential stage wrapped around the team's N-bit ripple-carry adder datapath.
- Feeds the adder: operand a from an internal accumulator register, operand b from an input stream, plus c_in.
- Consumes what the adder produces: registers sum back into the accumulator and tracks carry-out as an overflow/borrow flag.
- Accumulates a programmed number of unsigned operands per job, then presents one result on a valid/ready output.

Parameters:
- N, 8: datapath width in bits; operands, accumulator and result are N bits.
- CW, 4: width of the operand-count field; at most 2^CW-1 operands per job.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job launch; sampled only in IDLE.
- sub  in  1  job mode, captured at start: 0 = add, 1 = subtract operands from the accumulator.
- len  in  CW  number of operands in the job, captured at start.
- in_valid  in  1  operand available.
- in_ready  out  1  block accepts an operand this cycle.
- in_data  in  N  unsigned operand.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- result  out  N  final accumulator value.
- ovf  out  1  sticky flag: add carry-out or subtract borrow occurred during the job.
- busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, remaining=0, ovf=0, sub_q=0. Outputs: in_ready=0, out_valid=0, busy=0, result=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 -> acc<=0, ovf<=0, sub_q<=sub, remaining<=len.
  - Next state is ACCUM if len!=0; DONE if len==0 (result 0, ovf 0).
- ACCUM:
  - in_ready=1.
  - Handshake on in_valid&in_ready. Add mode: acc<=acc+in_data. Subtract mode: acc<=acc+~in_data+1.
  - Adder path: a=acc; b=in_data or its inverse; c_in=sub_q.
  - ovf |= c_out when adding; ovf |= ~c_out when subtracting.
  - remaining decrements by 1 per accepted operand. Accepting the operand when remaining==1 moves to DONE next cycle.
  - in_valid low stalls with no state change.
- DONE:
  - out_valid=1; result=acc; in_ready=0.
  - out_ready=1 -> IDLE next cycle. out_valid may wait indefinitely; result stays stable while waiting.
- Latency: result valid the cycle after the last operand handshake. Minimum job is len+1 cycles before out_valid.
- Throughput: one operand per cycle. No bubble between consecutive operands.
- Arithmetic: unsigned modulo 2^N. Wrap-around is legal and flagged via ovf.
- start outside IDLE is ignored, including a start in the same cycle as the out_ready handshake. The next job needs start while in IDLE.
- rst mid-job aborts immediately: partial acc is discarded and no out_valid is produced.
- result is registered, so the combinational adder output never drives a port.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: any add step with c_out=1 sets acc to all-ones; any subtract step with borrow sets acc to 0. ovf still sets.
- Undefined: modulo wrap as above.

Decomposition:
- Shared package nbit_acc_pkg holds:
  - state encoding: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10;
  - MODE_ADD=1'b0, MODE_SUB=1'b1.
- One natural sub-module, acc_add_path (combinational), which:
  - takes acc, in_data and sub_q;
  - forms b and c_in;
  - instantiates the N-bit ripple adder;
  - returns the next acc and the overflow bit, with saturation applied under ACC_SATURATE_EN.
- The FSM, counter and registers stay in the top module.

Test Plan (N=8, CW=4):
- Reset mid-job (rst pulse after 2 operands) -> state IDLE; out_valid, in_ready, result and ovf all 0. A later job of len=1, data 9 -> result 9.
- Add, len=3, data 10, 20, 30, valid every cycle -> out_valid one cycle after 3rd handshake, result=60, ovf=0.
- Add overflow, len=2, data 200, 100 -> result=44, ovf=1. With ACC_SATURATE_EN: result=255, ovf=1.
- Subtract, len=1, data 5 -> result=251, ovf=1 (borrow). With ACC_SATURATE_EN: result=0.
- len=0 start -> DONE next cycle, result=0, ovf=0, in_ready never asserted.
- Back-pressure and stalls: in_valid toggling 1,0,1 with len=2, data 7, 8 -> result=15. Hold out_ready=0 for 5 cycles -> result stable, start pulses ignored; out_ready=1 -> IDLE.
